// File: rtl/goomba_pkg.sv
// rtl/goomba_pkg.sv - sprite geometry, ROM bank encodings and goomba palette
package goomba_pkg;

  localparam int SPRITE_W = 20;
  localparam int SPRITE_H = 20;

  typedef enum logic [1:0] {
    BANK_WALK0  = 2'd0,
    BANK_WALK1  = 2'd1,
    BANK_SQUISH = 2'd2
  } bank_e;

  // Index 0 is transparent and never reaches the screen.
  localparam logic [23:0] PALETTE [0:15] = '{
    24'h000000, 24'h3C1E0A, 24'h8B4513, 24'hA0522D,
    24'hD2691E, 24'hF4A460, 24'hFFDEAD, 24'hFFFFFF,
    24'h202020, 24'h5C3317, 24'hC08040, 24'hE0B080,
    24'h703010, 24'hB86B3C, 24'hFFE4C4, 24'h101010
  };

  function automatic logic [23:0] palette(input logic [3:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/goomba_sprite_renderer_frame_tick_sync.sv
// rtl/goomba_sprite_renderer_frame_tick_sync.sv - frame_clk synchronizer and rising-edge pulse
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic [2:0] r_live;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_live  <= 3'b000;
    end else begin
      r_sync1 <= frame_clk;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_live  <= {r_live[1:0], 1'b1};
    end
  end

  // Edges are only trusted once r_prev holds a real sample, so a high level at release is not a tick.
  assign frame_tick = r_sync2 & ~r_prev & r_live[2];

endmodule

// File: rtl/goomba_sprite_renderer.sv
// rtl/goomba_sprite_renderer.sv - three-stage goomba sprite pipeline: ROM fetch, palette, aligned coords
module goomba_sprite_renderer
  import goomba_pkg::*;
#(
  parameter int SPRITE_PIXELS = 400,
  parameter int BLINK_FRAMES  = 8,
  parameter bit BLINK_EN      = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [31:0] DrawX,
  input  logic [31:0] DrawY,
  input  logic        is_goomba,
  input  logic [8:0]  goomba_address,
  input  logic        walk_num_goomba,
  input  logic        is_alive_goomba,
  output logic [10:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic        pix_valid,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic [31:0] draw_x_o,
  output logic [31:0] draw_y_o
);

  localparam int          CW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic [9:0]  PIX_LIM = 10'(SPRITE_PIXELS);

  logic          w_frame_tick;
  logic [CW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  bank_e         w_bank;
  logic          w_s1_ok;
  logic [23:0]   w_rgb;
  logic          r_s1_ok, r_s2_ok;
  logic [31:0]   r_s1_x, r_s1_y, r_s2_x, r_s2_y;

  frame_tick_sync u_frame_tick_sync (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (w_frame_tick)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_tick) begin
      if (r_blink_cnt == CNT_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_bank  = is_alive_goomba ? (walk_num_goomba ? BANK_WALK1 : BANK_WALK0) : BANK_SQUISH;
    w_s1_ok = is_goomba & ({1'b0, goomba_address} < PIX_LIM)
              & (is_alive_goomba | ~BLINK_EN | r_blink_phase);
    w_rgb   = palette(rom_data);
  end

  // The external ROM registers rom_data between S1 and S3, so S2 only carries side data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr  <= '0;
      r_s1_ok   <= 1'b0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
      r_s2_ok   <= 1'b0;
      r_s2_x    <= '0;
      r_s2_y    <= '0;
      pix_valid <= 1'b0;
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b     <= '0;
      draw_x_o  <= '0;
      draw_y_o  <= '0;
    end else begin
      rom_addr  <= {w_bank, goomba_address};
      r_s1_ok   <= w_s1_ok;
      r_s1_x    <= DrawX;
      r_s1_y    <= DrawY;
      r_s2_ok   <= r_s1_ok;
      r_s2_x    <= r_s1_x;
      r_s2_y    <= r_s1_y;
      pix_valid <= r_s2_ok & (rom_data != 4'd0);
      if (r_s2_ok && rom_data != 4'd0) begin
        pix_r <= w_rgb[23:16];
        pix_g <= w_rgb[15:8];
        pix_b <= w_rgb[7:0];
      end else begin
        pix_r <= '0;
        pix_g <= '0;
        pix_b <= '0;
      end
      draw_x_o <= r_s2_x;
      draw_y_o <= r_s2_y;
    end
  end

endmodule
